node_regfile: RTL and testbench

//  Parametrised ACC/BAK register file for one TIS-100 execution node; successor to the fixed 11-bit two-register block.

---
 rtl/node_regfile_pkg.sv | 23 ++
 rtl/node_regfile_sat_clamp.sv | 28 ++
 rtl/node_regfile.sv | 124 ++++++++++++
 tb/tb_node_regfile.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_regfile_pkg.sv
// node_regfile_pkg: shared op codes and defaults for the TIS-100 node
// register file, plus the backup-select width helper.
package node_regfile_pkg;

    localparam int TIS_WIDTH   = 11;
    localparam int TIS_MAX_VAL = 999;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_MOV = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3,
        OP_NEG = 3'd4,
        OP_SAV = 3'd5,
        OP_SWP = 3'd6,
        OP_CLR = 3'd7
    } op_e;

    function automatic int bsel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/node_regfile_sat_clamp.sv
// tis_sat_clamp: (WIDTH+1)-bit signed value clamped to
// [-MAX_VAL, MAX_VAL] and truncated to WIDTH bits, with overflow bit.
module tis_sat_clamp #(
    parameter int WIDTH   = 11,
    parameter int MAX_VAL = 999
) (
    input  logic signed [WIDTH:0]   din,
    output logic signed [WIDTH-1:0] dout,
    output logic                    ovf
);

    localparam logic signed [WIDTH:0] HI = (WIDTH+1)'(MAX_VAL);
    localparam logic signed [WIDTH:0] LO = -HI;

    // Clamp against the symmetric bound, flag when clamping occurred
    always_comb begin
        dout = din[WIDTH-1:0];
        ovf  = 1'b0;
        if (din > HI) begin
            dout = HI[WIDTH-1:0];
            ovf  = 1'b1;
        end else if (din < LO) begin
            dout = LO[WIDTH-1:0];
            ovf  = 1'b1;
        end
    end

endmodule

// File: rtl/node_regfile.sv
// node_regfile: ACC plus NUM_BAK banked BAK registers for one node.
// Macro NODE_REGFILE_SAT_FLAG_EN enables the registered sat flag.
module node_regfile
    import node_regfile_pkg::*;
#(
    parameter int WIDTH   = TIS_WIDTH,
    parameter int MAX_VAL = TIS_MAX_VAL,
    parameter int NUM_BAK = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic [2:0]                   instr,
    input  logic [bsel_w(NUM_BAK)-1:0]   bak_sel,
    input  logic signed [WIDTH-1:0]      input_val,
    output logic signed [WIDTH-1:0]      out,
    output logic                         acc_zero,
    output logic                         acc_neg,
    output logic                         sat
);

    localparam int BSEL_W = bsel_w(NUM_BAK);

    op_e                      op;
    logic signed [WIDTH-1:0]  acc;
    logic signed [WIDTH-1:0]  acc_nxt;
    logic signed [WIDTH-1:0]  bak [0:NUM_BAK-1];
    logic signed [WIDTH-1:0]  bak_rd;
    logic [BSEL_W-1:0]        sel_idx;
    logic signed [WIDTH:0]    ext_a;
    logic signed [WIDTH:0]    ext_b;
    logic signed [WIDTH:0]    ext_sum;
    logic signed [WIDTH-1:0]  clamped;
    logic                     ovf;
    logic                     is_arith;
    logic                     bak_wr;

    assign op       = op_e'(instr);
    assign out      = acc;
    assign is_arith = (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB);
    assign bak_wr   = (op == OP_SAV) || (op == OP_SWP);

    // Out-of-range backup selects fall back to entry 0
    always_comb begin
        sel_idx = '0;
        if (int'(bak_sel) < NUM_BAK) sel_idx = bak_sel;
    end

    // Read the selected backup entry
    always_comb begin
        bak_rd = '0;
        for (int i = 0; i < NUM_BAK; i++) begin
            if (sel_idx == BSEL_W'(i)) bak_rd = bak[i];
        end
    end

    // Widened operands; MOV adds input to zero so it is clamped too
    always_comb begin
        ext_a   = (op == OP_MOV) ? '0 : {acc[WIDTH-1], acc};
        ext_b   = {input_val[WIDTH-1], input_val};
        ext_sum = (op == OP_SUB) ? (ext_a - ext_b) : (ext_a + ext_b);
    end

    tis_sat_clamp #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_clamp (
        .din  (ext_sum),
        .dout (clamped),
        .ovf  (ovf)
    );

    // Next ACC value for the op being issued
    always_comb begin
        acc_nxt = acc;
        unique case (op)
            OP_NOP: acc_nxt = acc;
            OP_MOV: acc_nxt = clamped;
            OP_ADD: acc_nxt = clamped;
            OP_SUB: acc_nxt = clamped;
            OP_NEG: acc_nxt = -acc;
            OP_SAV: acc_nxt = acc;
            OP_SWP: acc_nxt = bak_rd;
            OP_CLR: acc_nxt = '0;
        endcase
    end

    // ACC, status flags and backup bank update
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            acc_zero <= 1'b1;
            acc_neg  <= 1'b0;
            for (int i = 0; i < NUM_BAK; i++) bak[i] <= '0;
        end else if (clk_en) begin
            acc      <= acc_nxt;
            acc_zero <= (acc_nxt == '0);
            acc_neg  <= acc_nxt[WIDTH-1];
            for (int i = 0; i < NUM_BAK; i++) begin
                if (bak_wr && (sel_idx == BSEL_W'(i))) bak[i] <= acc;
            end
        end
    end

`ifdef NODE_REGFILE_SAT_FLAG_EN
    logic sat_q;

    // Saturation flag: set by a clamping arithmetic op, cleared otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (clk_en) begin
            sat_q <= is_arith & ovf;
        end
    end

    assign sat = sat_q;
`else
    logic ovf_unused;
    assign ovf_unused = ovf & is_arith;
    assign sat        = 1'b0;
`endif

endmodule

// File: tb/tb_node_regfile.sv
// tb_node_regfile: directed checks of the node register file,
// default instance plus a NUM_BAK=4 instance sharing stimulus.
module tb_node_regfile;
    import node_regfile_pkg::*;

`ifdef NODE_REGFILE_SAT_FLAG_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_en;
    logic [2:0]         instr;
    logic [0:0]         bsel;
    logic [1:0]         bsel4;
    logic signed [10:0] ival;
    logic signed [10:0] out;
    logic               zero;
    logic               neg;
    logic               sat;
    logic signed [10:0] out4;
    logic               zero4;
    logic               neg4;
    logic               sat4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    node_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .instr     (instr),
        .bak_sel   (bsel),
        .input_val (ival),
        .out       (out),
        .acc_zero  (zero),
        .acc_neg   (neg),
        .sat       (sat)
    );

    node_regfile #(.NUM_BAK(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .instr     (instr),
        .bak_sel   (bsel4),
        .input_val (ival),
        .out       (out4),
        .acc_zero  (zero4),
        .acc_neg   (neg4),
        .sat       (sat4)
    );

    task automatic cyc(input bit en, input bit rst, input op_e op,
                       input int val, input int sel);
        clk_en = en;
        reset  = rst;
        instr  = op;
        ival   = 11'(val);
        bsel   = 1'(sel);
        bsel4  = 2'(sel);
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, OP_MOV, 77, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, OP_NOP, 0, 0);
            n_tests++;
            if (out !== 11'sd0 || zero !== 1'b1 ||
                neg !== 1'b0 || sat !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_nop%0d out=%0d z=%b n=%b s=%b req 0 1 0 0",
                         i, out, zero, neg, sat);
            end
        end
    endtask

    task automatic test_add_sat();
        cyc(1'b1, 1'b0, OP_MOV, 600, 0);
        n_tests++;
        if (out !== 11'sd600 || sat !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL mov600 out=%0d s=%b z=%b req 600 0 0", out, sat, zero);
        end
        cyc(1'b1, 1'b0, OP_ADD, 600, 0);
        n_tests++;
        if (out !== 11'sd999 || sat !== SE) begin
            n_fail++;
            $display("FAIL add600 out=%0d s=%b req 999 %b", out, sat, SE);
        end
        cyc(1'b1, 1'b0, OP_NOP, 0, 0);
        n_tests++;
        if (out !== 11'sd999 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_clr out=%0d s=%b req 999 0", out, sat);
        end
    endtask

    task automatic test_sub_neg();
        cyc(1'b1, 1'b0, OP_MOV, -500, 0);
        n_tests++;
        if (out !== -11'sd500 || neg !== 1'b1 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL mov_m500 out=%0d n=%b s=%b req -500 1 0", out, neg, sat);
        end
        cyc(1'b1, 1'b0, OP_SUB, 700, 0);
        n_tests++;
        if (out !== -11'sd999 || neg !== 1'b1 || sat !== SE) begin
            n_fail++;
            $display("FAIL sub700 out=%0d n=%b s=%b req -999 1 %b",
                     out, neg, sat, SE);
        end
        cyc(1'b1, 1'b0, OP_NEG, 0, 0);
        n_tests++;
        if (out !== 11'sd999 || neg !== 1'b0 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL neg out=%0d n=%b s=%b req 999 0 0", out, neg, sat);
        end
    endtask

    task automatic test_mov_clamp();
        cyc(1'b1, 1'b0, OP_MOV, -1024, 0);
        n_tests++;
        if (out !== -11'sd999 || sat !== SE) begin
            n_fail++;
            $display("FAIL mov_m1024 out=%0d s=%b req -999 %b", out, sat, SE);
        end
        cyc(1'b1, 1'b0, OP_MOV, 1023, 0);
        n_tests++;
        if (out !== 11'sd999 || sat !== SE) begin
            n_fail++;
            $display("FAIL mov1023 out=%0d s=%b req 999 %b", out, sat, SE);
        end
        cyc(1'b1, 1'b0, OP_SUB, -1024, 0);
        n_tests++;
        if (out !== 11'sd999 || sat !== SE) begin
            n_fail++;
            $display("FAIL sub_m1024 out=%0d s=%b req 999 %b", out, sat, SE);
        end
        cyc(1'b1, 1'b0, OP_CLR, 5, 0);
        n_tests++;
        if (out !== 11'sd0 || zero !== 1'b1 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL clr out=%0d z=%b s=%b req 0 1 0", out, zero, sat);
        end
    endtask

    task automatic test_bank1();
        cyc(1'b1, 1'b1, OP_NOP, 0, 0);
        cyc(1'b1, 1'b0, OP_MOV, 3, 0);
        cyc(1'b1, 1'b0, OP_SAV, 0, 1);
        cyc(1'b1, 1'b0, OP_CLR, 0, 0);
        cyc(1'b1, 1'b0, OP_SWP, 0, 0);
        n_tests++;
        if (out !== 11'sd3) begin
            n_fail++;
            $display("FAIL bank1_swp out=%0d req 3", out);
        end
        cyc(1'b1, 1'b0, OP_SWP, 0, 1);
        n_tests++;
        if (out !== 11'sd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL bank1_swp2 out=%0d z=%b req 0 1", out, zero);
        end
    endtask

    task automatic test_bank4();
        cyc(1'b1, 1'b1, OP_NOP, 0, 0);
        cyc(1'b1, 1'b0, OP_MOV, 5, 0);
        cyc(1'b1, 1'b0, OP_SAV, 0, 2);
        cyc(1'b1, 1'b0, OP_MOV, 7, 0);
        cyc(1'b1, 1'b0, OP_SWP, 0, 2);
        n_tests++;
        if (out4 !== 11'sd5) begin
            n_fail++;
            $display("FAIL bank4_swp_b2 out=%0d req 5", out4);
        end
        cyc(1'b1, 1'b0, OP_SWP, 0, 0);
        n_tests++;
        if (out4 !== 11'sd0) begin
            n_fail++;
            $display("FAIL bank4_swp_b0 out=%0d req 0", out4);
        end
        cyc(1'b1, 1'b0, OP_SWP, 0, 2);
        n_tests++;
        if (out4 !== 11'sd7) begin
            n_fail++;
            $display("FAIL bank4_swp_b2b out=%0d req 7", out4);
        end
        cyc(1'b1, 1'b0, OP_SWP, 0, 3);
        n_tests++;
        if (out4 !== 11'sd0) begin
            n_fail++;
            $display("FAIL bank4_b3 out=%0d req 0", out4);
        end
        cyc(1'b1, 1'b0, OP_SWP, 0, 1);
        n_tests++;
        if (out4 !== 11'sd0 || zero4 !== 1'b1) begin
            n_fail++;
            $display("FAIL bank4_b1 out=%0d z=%b req 0 1", out4, zero4);
        end
        cyc(1'b1, 1'b0, OP_SWP, 0, 3);
        n_tests++;
        if (out4 !== 11'sd7) begin
            n_fail++;
            $display("FAIL bank4_b3b out=%0d req 7", out4);
        end
    endtask

    task automatic test_hold();
        cyc(1'b1, 1'b0, OP_MOV, 1023, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, OP_ADD, 1, 0);
            n_tests++;
            if (out !== 11'sd999 || zero !== 1'b0 ||
                neg !== 1'b0 || sat !== SE) begin
                n_fail++;
                $display("FAIL hold%0d out=%0d z=%b n=%b s=%b req 999 0 0 %b",
                         i, out, zero, neg, sat, SE);
            end
        end
        cyc(1'b1, 1'b0, OP_ADD, -4, 0);
        n_tests++;
        if (out !== 11'sd995 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_resume out=%0d s=%b req 995 0", out, sat);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, OP_MOV, -100, 0);
        cyc(1'b1, 1'b1, OP_MOV, 42, 0);
        n_tests++;
        if (out !== 11'sd0 || zero !== 1'b1 || neg !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mov42 out=%0d z=%b n=%b req 0 1 0", out, zero, neg);
        end
        cyc(1'b1, 1'b0, OP_MOV, 42, 0);
        cyc(1'b1, 1'b0, OP_SAV, 0, 0);
        cyc(1'b0, 1'b1, OP_NOP, 0, 0);
        n_tests++;
        if (out !== 11'sd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_no_en out=%0d z=%b req 0 1", out, zero);
        end
        cyc(1'b1, 1'b0, OP_SWP, 0, 0);
        n_tests++;
        if (out !== 11'sd0) begin
            n_fail++;
            $display("FAIL rst_bak out=%0d req 0", out);
        end
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b0;
        instr  = 3'd0;
        bsel   = '0;
        bsel4  = '0;
        ival   = '0;
        test_reset();
        test_add_sat();
        test_sub_neg();
        test_mov_clamp();
        test_bank1();
        test_bank4();
        test_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
